// File: rtl/io_pkg.sv
// io_pkg: shared state type, default sizes and port-select range check for io_port_bank
package io_pkg;
  typedef enum logic {S_IDLE, S_WAIT} io_state_t;
  localparam int IO_WIDTH_DEF = 16;
  localparam int IO_PORTS_DEF = 4;
  function automatic logic sel_ok(input logic [31:0] sel, input int unsigned n);
    return sel < n;
  endfunction
endpackage

// File: rtl/io_in_fifo.sv
// io_in_fifo: per-port input FIFO with count-based full/empty.
// Ports: clk, reset (async, active-high), push_i/pop_i (ignored when full/empty),
//        din_i, dout_o (head entry), full_o, empty_o.
module io_in_fifo #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             push, pop;
  assign full_o  = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign empty_o = cnt_q == '0;
  assign dout_o  = mem_q[rptr_q];
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & ~empty_o;
  // pointers wrap naturally because FIFO_DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(push);
      rptr_q <= rptr_q + AW'(pop);
      cnt_q  <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // storage needs no reset: the count alone decides which entries are live
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= din_i;
  end
endmodule

// File: rtl/io_port_bank.sv
// io_port_bank: NUM_PORTS input FIFOs and output latches for the memory-stage IN/OUT path.
// Ports: clk, reset (async, active-high); ioe/ior/iow/port_sel/wdata from EM;
//        rdata/rvalid (registered read result), stall (read pending on empty port);
//        port_in_data/valid/ready (external input handshake), port_out_data/strobe,
//        irq (data-available; generated only when IO_IRQ_EN is defined, else 0).
module io_port_bank import io_pkg::*; #(
  parameter int WIDTH      = IO_WIDTH_DEF,
  parameter int NUM_PORTS  = IO_PORTS_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int PSEL_W     = $clog2(NUM_PORTS) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ioe,
  input  logic                       ior,
  input  logic                       iow,
  input  logic [PSEL_W-1:0]          port_sel,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       rvalid,
  output logic                       stall,
  input  logic [NUM_PORTS*WIDTH-1:0] port_in_data,
  input  logic [NUM_PORTS-1:0]       port_in_valid,
  output logic [NUM_PORTS-1:0]       port_in_ready,
  output logic [NUM_PORTS*WIDTH-1:0] port_out_data,
  output logic [NUM_PORTS-1:0]       port_out_strobe,
  output logic                       irq
);
  localparam int SW = PSEL_W - 1;
  io_state_t                state_q, state_d;
  logic [SW-1:0]            wait_sel_q, wait_sel_d, idx;
  logic [WIDTH-1:0]         rdata_q, rdata_d;
  logic                     rvalid_q, rvalid_d;
  logic [NUM_PORTS*WIDTH-1:0] out_q;
  logic [NUM_PORTS-1:0]     strobe_q, pop_vec, empty_v, full_v;
  logic [WIDTH-1:0]         head [NUM_PORTS];
  logic                     rd_req, wr_req, in_range;
  assign rd_req   = ioe & ior & ~iow;
  assign wr_req   = ioe & iow & ~ior;
  assign in_range = sel_ok(32'(port_sel), NUM_PORTS);
  assign idx      = port_sel[SW-1:0];
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fifo
    io_in_fifo #(.WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push_i (port_in_valid[p]),
      .pop_i  (pop_vec[p]),
      .din_i  (port_in_data[p*WIDTH +: WIDTH]),
      .dout_o (head[p]),
      .full_o (full_v[p]),
      .empty_o(empty_v[p])
    );
  end
  assign port_in_ready = ~full_v;
  // no bypass: a read of an empty port always stalls at least the cycle it is issued
  always_comb begin
    state_d    = state_q;
    wait_sel_d = wait_sel_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    stall      = 1'b0;
    pop_vec    = '0;
    if (state_q == S_WAIT) begin
      stall = empty_v[wait_sel_q];
      if (!empty_v[wait_sel_q]) begin
        pop_vec[wait_sel_q] = 1'b1;
        rdata_d  = head[wait_sel_q];
        rvalid_d = 1'b1;
        state_d  = S_IDLE;
      end
    end else if (rd_req) begin
      if (!in_range) begin
        rdata_d  = '0;
        rvalid_d = 1'b1;
      end else if (empty_v[idx]) begin
        stall      = 1'b1;
        wait_sel_d = idx;
        state_d    = S_WAIT;
      end else begin
        pop_vec[idx] = 1'b1;
        rdata_d  = head[idx];
        rvalid_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_sel_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      out_q      <= '0;
      strobe_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_sel_q <= wait_sel_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      strobe_q   <= '0;
      if (wr_req && in_range) begin
        out_q[int'(idx)*WIDTH +: WIDTH] <= wdata;
        strobe_q[idx] <= 1'b1;
      end
    end
  end
  assign rdata           = rdata_q;
  assign rvalid          = rvalid_q;
  assign port_out_data   = out_q;
  assign port_out_strobe = strobe_q;
`ifdef IO_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= ~&empty_v;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: directed scoreboard bench for io_port_bank
module tb_io_port_bank;
  import io_pkg::*;
  localparam int W = 16, N = 4, PW = 3;
`ifdef IO_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, ioe = 1'b0, ior = 1'b0, iow = 1'b0;
  logic [PW-1:0] port_sel = '0;
  logic [W-1:0] wdata = '0, rdata;
  logic rvalid, stall, irq;
  logic [N*W-1:0] port_in_data = '0, port_out_data;
  logic [N-1:0] port_in_valid = '0, port_in_ready, port_out_strobe;
  int checks = 0, errors = 0, nst;
  logic [W-1:0] rd_q [$];
  logic [PW+W-1:0] st_q [$];
  logic [W-1:0] out_m [N];

  io_port_bank dut (
    .clk(clk), .reset(reset), .ioe(ioe), .ior(ior), .iow(iow), .port_sel(port_sel),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .stall(stall),
    .port_in_data(port_in_data), .port_in_valid(port_in_valid), .port_in_ready(port_in_ready),
    .port_out_data(port_out_data), .port_out_strobe(port_out_strobe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ioe = 1'b0; ior = 1'b0; iow = 1'b0; port_in_valid = '0;
  endtask

  task automatic rd(input int p);
    ioe = 1'b1; ior = 1'b1; iow = 1'b0; port_sel = PW'(p);
  endtask

  task automatic wr(input int p, input logic [W-1:0] d);
    ioe = 1'b1; ior = 1'b0; iow = 1'b1; port_sel = PW'(p); wdata = d;
  endtask

  task automatic push(input int p, input logic [W-1:0] d);
    port_in_valid[p] = 1'b1; port_in_data[p*W +: W] = d;
  endtask

  // monitor: compares every rvalid / strobe against the scoreboard queues
  initial begin
    logic [W-1:0] e;
    logic [PW+W-1:0] s;
    forever begin
      @(negedge clk);
      if (rvalid) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rvalid_unexpected: got rdata %h expected no rvalid", rdata);
        end else begin
          e = rd_q.pop_front();
          if (rdata !== e) begin
            errors++;
            $display("FAIL rdata: got %h expected %h", rdata, e);
          end
        end
      end
      if (port_out_strobe != '0) begin
        checks++;
        if (st_q.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected: got strobe %b expected none", port_out_strobe);
        end else begin
          s = st_q.pop_front();
          if (port_out_strobe !== N'(1) << s[PW+W-1:W] || port_out_data[int'(s[PW+W-1:W])*W +: W] !== s[W-1:0]) begin
            errors++;
            $display("FAIL strobe: got strobe %b data %h expected port %0d data %h",
                     port_out_strobe, port_out_data, s[PW+W-1:W], s[W-1:0]);
          end
        end
      end
    end
  end

  initial begin
    for (int p = 0; p < N; p++) out_m[p] = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    // build up state, then reset mid-stream while waiting
    push(0, 16'h1111); tick(); idle();
    rd(0); rd_q.push_back(16'h1111); tick(); idle();
    wr(0, 16'h7777); st_q.push_back({3'd0, 16'h7777}); tick(); idle();
    rd(1); tick(); idle(); #1;
    chk("stall_before_reset", stall, 1);
    reset = 1'b1; #1;
    chk("rst_stall", stall, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_ready", port_in_ready, 4'b1111);
    chk("rst_out", port_out_data, 0);
    chk("rst_strobe", port_out_strobe, 0);
    chk("rst_irq", irq, 0);
    chk("rst_state", 32'(dut.state_q), 32'(S_IDLE));
    tick(); reset = 1'b0; tick();
    // simple push then read on port 2, irq follows count one cycle late
    push(2, 16'h1234); tick(); idle();
    chk("ready2_after_push", port_in_ready[2], 1);
    chk("irq_not_yet", irq, 0);
    rd(2); rd_q.push_back(16'h1234); #1;
    chk("no_stall_p2", stall, 0);
    tick(); idle();
    chk("irq_set", irq, IRQ);
    tick();
    chk("irq_clear", irq, 0);
    // empty read on port 1, data arrives two cycles into the stall
    nst = 0;
    rd(1); #1; if (stall) nst++;
    tick(); idle(); #1; if (stall) nst++;
    tick(); push(1, 16'hBEEF); rd_q.push_back(16'hBEEF); #1; if (stall) nst++;
    tick(); idle(); #1;
    chk("stall_released", stall, 0);
    tick();
    chk("stall_cycles", nst, 3);
    chk("state_idle", 32'(dut.state_q), 32'(S_IDLE));
    // fill port 0, overflow dropped
    for (int i = 0; i < 4; i++) begin
      push(0, 16'h0A00 + 16'(i)); #1;
      chk("ready0_filling", port_in_ready[0], 1);
      tick();
    end
    push(0, 16'h5555); #1;
    chk("ready0_full", port_in_ready[0], 0);
    tick(); idle();
    rd(0); rd_q.push_back(16'h0A00); tick();
    push(0, 16'h0B00); rd_q.push_back(16'h0A01); #1;
    chk("ready0_push_pop", port_in_ready[0], 1);
    tick(); idle();
    push(0, 16'h0B01); tick(); idle(); #1;
    chk("ready0_full_again", port_in_ready[0], 0);
    rd(0);
    rd_q.push_back(16'h0A02); rd_q.push_back(16'h0A03);
    rd_q.push_back(16'h0B00); rd_q.push_back(16'h0B01);
    for (int i = 0; i < 4; i++) begin
      #1; chk("b2b_no_stall", stall, 0);
      tick();
    end
    idle(); #1;
    chk("ready0_drained", port_in_ready[0], 1);
    // minimum stall: push in the same cycle as the empty read
    rd(0); push(0, 16'h0C00); rd_q.push_back(16'h0C00); #1;
    chk("min_stall_on", stall, 1);
    tick(); idle(); #1;
    chk("min_stall_off", stall, 0);
    tick();
    // outputs
    wr(3, 16'hA5A5); st_q.push_back({3'd3, 16'hA5A5}); out_m[3] = 16'hA5A5; tick(); idle();
    tick();
    wr(5, 16'hFFFF); tick(); idle();
    ioe = 1'b1; ior = 1'b1; iow = 1'b1; port_sel = 3'd1; wdata = 16'hDEAD; #1;
    chk("both_no_stall", stall, 0);
    tick(); idle(); tick();
    for (int p = 0; p < N; p++) chk("out_hold", port_out_data[p*W +: W], out_m[p]);
    // out-of-range read returns 0 without stall
    rd(6); rd_q.push_back(16'h0000); #1;
    chk("oor_no_stall", stall, 0);
    tick(); idle();
    repeat (3) tick();
    chk("irq_end", irq, 0);
    chk("rd_queue_left", rd_q.size(), 0);
    chk("st_queue_left", st_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish before 20000");
    $fatal(1);
  end
endmodule
